// File: rtl/hc595_scan_scheduler_pkg.sv
// Shared definitions for the 74HC595 display scan scheduler:
//   - scan FSM state encoding
//   - frame and digit-count constants
//   - active-high 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - counter-width helper that stays >= 1 bit for tiny parameters
package hc595_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } scan_state_e;

  localparam int FRAME_BITS = 16;
  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  // Width of a down-counter that must hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hc595_scan_scheduler_bcd_to_seg7.sv
// BCD digit + decimal point to 8-bit segment byte {dp,g,f,e,d,c,b,a}.
// Codes 10-15 light no segments; dp is passed through regardless.
// Ports:
//   bcd  in  4  BCD digit
//   dp   in  1  decimal point enable
//   seg  out 8  segment byte, polarity set by ACTIVE_LOW (0: lit = 1)
module bcd_to_seg7
  import hc595_scan_scheduler_pkg::*;
#(
  parameter int ACTIVE_LOW = 0
) (
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG7_BLANK;
    case (bcd)
      4'd0:    pat = SEG7_0;
      4'd1:    pat = SEG7_1;
      4'd2:    pat = SEG7_2;
      4'd3:    pat = SEG7_3;
      4'd4:    pat = SEG7_4;
      4'd5:    pat = SEG7_5;
      4'd6:    pat = SEG7_6;
      4'd7:    pat = SEG7_7;
      4'd8:    pat = SEG7_8;
      4'd9:    pat = SEG7_9;
      default: pat = SEG7_BLANK;
    endcase
  end

  assign seg = (ACTIVE_LOW != 0) ? ~{dp, pat} : {dp, pat};

endmodule

// File: rtl/hc595_scan_scheduler.sv
// Continuous scan scheduler driving a 16-bit 74HC595 chain for a 6-digit
// 7-segment display. Each slot loads one digit into a frame {seg, sel},
// shifts it out MSB first, pulses RCK, then holds before the next digit.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | capture digit idx, dot, blank into the frame register (1 cycle)
// SHIFT | 16 bits out, SCK low then high for SCLK_DIV cycles per bit
// LATCH | RCK high for SCLK_DIV cycles
// HOLD  | display dwell for SCAN_HOLD cycles, idx advances on exit
//
// Ports:
//   clk_in        in   1   system clock
//   rst_n_in      in   1   async active-low reset
//   digit_bcd_in  in   24  six BCD digits, [3:0] = sec_ge ... [23:20] = hour_shi
//   dot_in        in   6   per-digit decimal point
//   blank_in      in   1   blank all digit selects in frames loaded while high
//   frame_busy    out  1   high during LOAD/SHIFT/LATCH
//   frame_done    out  1   one-cycle pulse when LATCH ends
//   rclk_out      out  1   595 RCK
//   sclk_out      out  1   595 SCK
//   sdio_out      out  1   595 SER
module hc595_scan_scheduler
  import hc595_scan_scheduler_pkg::*;
#(
  parameter int SCLK_DIV       = 4,
  parameter int SCAN_HOLD      = 12000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [23:0] digit_bcd_in,
  input  logic [5:0]  dot_in,
  input  logic        blank_in,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        rclk_out,
  output logic        sclk_out,
  output logic        sdio_out
);

  // One shared down-counter times both the SCK half-periods and the dwell.
  localparam int TMR_MAX = (SCLK_DIV > SCAN_HOLD) ? SCLK_DIV : SCAN_HOLD;
  localparam int TW      = cnt_width(TMR_MAX);
  localparam int BW      = cnt_width(FRAME_BITS);

  localparam logic [TW-1:0] DIV_LD  = TW'(SCLK_DIV - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(SCAN_HOLD - 1);
  localparam logic [BW-1:0] BIT_LD  = BW'(FRAME_BITS - 1);
  localparam logic [2:0]    IDX_TOP = 3'(NUM_DIGITS - 1);

  scan_state_e            st_q, st_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   phase_q, phase_d;
  logic [2:0]             idx_q, idx_d;
  logic [FRAME_BITS-1:0]  frame_q, frame_d;
  logic                   done_d, busy_d, rclk_d, sclk_d, sdio_d;

  logic [23:0] bcd_sh;
  logic [5:0]  dot_sh;
  logic [7:0]  seg;
  logic [7:0]  sel_raw;
  logic [7:0]  sel;

  // Shift-based digit pick keeps the select in range for every idx encoding.
  assign bcd_sh  = digit_bcd_in >> {idx_q, 2'b00};
  assign dot_sh  = dot_in >> idx_q;
  assign sel_raw = blank_in ? 8'h00 : (8'h01 << idx_q);
  assign sel     = (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;

  bcd_to_seg7 #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_enc (
    .bcd (bcd_sh[3:0]),
    .dp  (dot_sh[0]),
    .seg (seg)
  );

  always_comb begin
    st_d    = st_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    done_d  = 1'b0;

    case (st_q)
      ST_LOAD: begin
        frame_d = {seg, sel};
        st_d    = ST_SHIFT;
        tmr_d   = DIV_LD;
        bit_d   = BIT_LD;
        phase_d = 1'b0;
      end
      ST_SHIFT: begin
        if (tmr_q == '0) begin
          tmr_d = DIV_LD;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of a high phase: next bit appears as SCK drops.
            phase_d = 1'b0;
            if (bit_q == '0) begin
              st_d = ST_LATCH;
            end else begin
              bit_d   = bit_q - 1'b1;
              frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
            end
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_LATCH: begin
        if (tmr_q == '0) begin
          st_d   = ST_HOLD;
          tmr_d  = HOLD_LD;
          done_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) begin
          st_d  = ST_LOAD;
          idx_d = (idx_q == IDX_TOP) ? 3'd0 : idx_q + 3'd1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: st_d = ST_LOAD;
    endcase

    // Pin outputs are registered from the next state so they never glitch.
    busy_d = (st_d != ST_HOLD);
    rclk_d = (st_d == ST_LATCH);
    sclk_d = (st_d == ST_SHIFT) && phase_d;
    sdio_d = (st_d == ST_SHIFT) ? frame_d[FRAME_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st_q       <= ST_LOAD;
      tmr_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      idx_q      <= 3'd0;
      frame_q    <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      rclk_out   <= 1'b0;
      sclk_out   <= 1'b0;
      sdio_out   <= 1'b0;
    end else begin
      st_q       <= st_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      frame_busy <= busy_d;
      frame_done <= done_d;
      rclk_out   <= rclk_d;
      sclk_out   <= sclk_d;
      sdio_out   <= sdio_d;
    end
  end

endmodule

// File: tb/tb_hc595_scan_scheduler.sv
`timescale 1ns/1ps
module tb_hc595_scan_scheduler;

  localparam int SCLK_DIV  = 2;
  localparam int SCAN_HOLD = 10;
  localparam int PERIOD    = 1 + 33 * SCLK_DIV + SCAN_HOLD;   // 77
  localparam int C_PERIOD  = 1 + 33 * 1 + 1;                  // 35

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] digit_bcd = 24'h0;
  logic [5:0]  dot = 6'h0;
  logic        blank = 1'b0;

  logic busy, done, rclk, sclk, sdio;
  logic c_busy, c_done, c_rclk, c_sclk, c_sdio;

  always #5 clk = ~clk;

  hc595_scan_scheduler #(
    .SCLK_DIV(SCLK_DIV), .SCAN_HOLD(SCAN_HOLD), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .digit_bcd_in(digit_bcd), .dot_in(dot), .blank_in(blank),
    .frame_busy(busy), .frame_done(done), .rclk_out(rclk), .sclk_out(sclk), .sdio_out(sdio)
  );

  hc595_scan_scheduler #(
    .SCLK_DIV(1), .SCAN_HOLD(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) c_dut (
    .clk_in(clk), .rst_n_in(rst_n), .digit_bcd_in(digit_bcd), .dot_in(dot), .blank_in(blank),
    .frame_busy(c_busy), .frame_done(c_done), .rclk_out(c_rclk), .sclk_out(c_sclk), .sdio_out(c_sdio)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rck_count = 0;

  logic [15:0] exp_q[$], got_q[$];
  int          nbits_q[$], rckw_q[$], done_t_q[$];
  logic [15:0] c_exp_q[$], c_got_q[$];
  int          c_edges_q[$], c_done_t_q[$];

  // Reference frame: common-anode segments, active-low selects.
  function automatic logic [15:0] model(input logic [23:0] d, input logic [5:0] dt,
                                        input logic bl, input int idx);
    logic [3:0] b;
    logic [6:0] p;
    logic [7:0] sg, sl;
    b = d[4*idx +: 4];
    case (b)
      4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
      4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
      4'd8: p = 7'h7F;  4'd9: p = 7'h6F;  default: p = 7'h00;
    endcase
    sg = ~{dt[idx], p};
    sl = bl ? 8'hFF : ~(8'h01 << idx);
    return {sg, sl};
  endfunction

  // Monitor / scoreboard feed for both instances.
  logic        s_blank;
  logic [23:0] s_digit;
  logic [5:0]  s_dot;
  logic        p_busy = 0, p_sclk = 0, p_rclk = 0, load_next = 1;
  logic        c_p_busy = 0, c_p_sclk = 0, c_p_rclk = 0, c_load_next = 1;
  logic [15:0] shreg = 0, c_shreg = 0;
  int          nbits = 0, rckw = 0, m_idx = 0, c_edges = 0, c_idx = 0;

  always @(posedge clk) begin
    s_digit = digit_bcd;
    s_dot   = dot;
    s_blank = blank;
    #1;
    cyc++;
    if (!rst_n) begin
      p_busy = 0; p_sclk = 0; p_rclk = 0; load_next = 1;
      nbits = 0; rckw = 0; m_idx = 0; exp_q.delete();
      c_p_busy = 0; c_p_sclk = 0; c_p_rclk = 0; c_load_next = 1;
      c_edges = 0; c_idx = 0; c_exp_q.delete();
    end else begin
      // Main instance: the edge after busy rises is the capture edge,
      // except right after reset where the first edge itself captures.
      if (load_next) begin
        exp_q.push_back(model(s_digit, s_dot, s_blank, m_idx));
        m_idx = (m_idx == 5) ? 0 : m_idx + 1;
        nbits = 0;
        load_next = 0;
      end else if (busy && !p_busy) begin
        load_next = 1;
      end
      if (sclk && !p_sclk) begin shreg = {shreg[14:0], sdio}; nbits++; end
      if (rclk && !p_rclk) begin got_q.push_back(shreg); nbits_q.push_back(nbits); rck_count++; end
      if (rclk) rckw++;
      else if (p_rclk) begin rckw_q.push_back(rckw); rckw = 0; end
      if (done) done_t_q.push_back(cyc);
      p_busy = busy; p_sclk = sclk; p_rclk = rclk;

      if (c_load_next) begin
        c_exp_q.push_back(model(s_digit, s_dot, s_blank, c_idx));
        c_idx = (c_idx == 5) ? 0 : c_idx + 1;
        c_edges = 0;
        c_load_next = 0;
      end else if (c_busy && !c_p_busy) begin
        c_load_next = 1;
      end
      if (c_sclk && !c_p_sclk) begin c_shreg = {c_shreg[14:0], c_sdio}; c_edges++; end
      if (c_rclk && !c_p_rclk) begin c_got_q.push_back(c_shreg); c_edges_q.push_back(c_edges); end
      if (c_done) c_done_t_q.push_back(cyc);
      c_p_busy = c_busy; c_p_sclk = c_sclk; c_p_rclk = c_rclk;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got_q.delete(); nbits_q.delete(); rckw_q.delete(); done_t_q.delete();
    c_got_q.delete(); c_edges_q.delete(); c_done_t_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    digit_bcd = 24'h123456; dot = 6'h00; blank = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rclk, sclk, sdio} !== 5'b0)
      $display("FAIL reset_outputs got %b want 00000", {busy, done, rclk, sclk, sdio});
    else passes++;
    checks++;
    if ({c_busy, c_done, c_rclk, c_sclk, c_sdio} !== 5'b0)
      $display("FAIL reset_outputs_corner got %b want 00000", {c_busy, c_done, c_rclk, c_sclk, c_sdio});
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_release got %b want 1", busy);
    else passes++;
  endtask

  task automatic test_frames();
    int k = 0;
    logic [15:0] g, e;
    while (done_t_q.size() < 3 && k < 4 * PERIOD) begin @(posedge clk); #2; k++; end
    checks++;
    if (done_t_q.size() < 3 || got_q.size() < 3) begin
      $display("FAIL frames_timeout got %0d frames want 3", got_q.size());
      return;
    end else passes++;
    for (int i = 0; i < 3; i++) begin
      g = got_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) $display("FAIL frame_sb[%0d] got %h want %h", i, g, e);
      else passes++;
      if (i == 0) begin
        checks++;
        if (g !== 16'h82FE) $display("FAIL frame0 got %h want 82fe", g);
        else passes++;
      end else if (i == 1) begin
        checks++;
        if (g !== 16'h92FD) $display("FAIL frame1 got %h want 92fd", g);
        else passes++;
      end
      checks++;
      if (nbits_q[i] !== 16) $display("FAIL sck_edges[%0d] got %0d want 16", i, nbits_q[i]);
      else passes++;
      checks++;
      if (rckw_q[i] !== SCLK_DIV) $display("FAIL rck_width[%0d] got %0d want %0d", i, rckw_q[i], SCLK_DIV);
      else passes++;
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (done_t_q[i] - done_t_q[i-1] !== PERIOD)
        $display("FAIL done_period[%0d] got %0d want %0d", i, done_t_q[i] - done_t_q[i-1], PERIOD);
      else passes++;
    end
    checks++;
    if (rck_count !== 3) $display("FAIL rck_count got %0d want 3", rck_count);
    else passes++;
  endtask

  task automatic test_scan_wrap();
    int k = 0;
    logic [15:0] g, e;
    logic [7:0] sel_exp [7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFE};
    do_reset();
    while (got_q.size() < 7 && k < 8 * PERIOD) begin @(posedge clk); #2; k++; end
    checks++;
    if (got_q.size() < 7) begin
      $display("FAIL wrap_timeout got %0d frames want 7", got_q.size());
      return;
    end else passes++;
    for (int i = 0; i < 7; i++) begin
      g = got_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      checks++;
      if (g[7:0] !== sel_exp[i]) $display("FAIL wrap_sel[%0d] got %h want %h", i, g[7:0], sel_exp[i]);
      else passes++;
      checks++;
      if (g !== e) $display("FAIL wrap_frame[%0d] got %h want %h", i, g, e);
      else passes++;
    end
  endtask

  task automatic test_capture();
    int k = 0;
    logic [15:0] g, e;
    digit_bcd = 24'h12345B; dot = 6'b000001; blank = 1'b0;
    do_reset();
    while (got_q.size() < 1 && k < 2 * PERIOD) begin @(posedge clk); #2; k++; end
    checks++;
    if (got_q.size() < 1) begin $display("FAIL cap_timeout0"); return; end else passes++;
    g = got_q.pop_front();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (g !== 16'h7FFE) $display("FAIL code_b_dot got %h want 7ffe", g);
    else passes++;
    checks++;
    if (g !== e) $display("FAIL code_b_sb got %h want %h", g, e);
    else passes++;

    blank = 1'b1;
    k = 0;
    while (got_q.size() < 1 && k < 2 * PERIOD) begin @(posedge clk); #2; k++; end
    checks++;
    if (got_q.size() < 1) begin $display("FAIL cap_timeout1"); return; end else passes++;
    g = got_q.pop_front();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (g !== 16'h92FF) $display("FAIL blank_frame got %h want 92ff", g);
    else passes++;
    checks++;
    if (g !== e) $display("FAIL blank_sb got %h want %h", g, e);
    else passes++;

    blank = 1'b0;
    k = 0;
    while (exp_q.size() < 1 && k < 2 * PERIOD) begin @(posedge clk); #2; k++; end
    repeat (10) @(negedge clk);
    digit_bcd = 24'h999999; dot = 6'h3F; blank = 1'b1;
    k = 0;
    while (got_q.size() < 1 && k < 2 * PERIOD) begin @(posedge clk); #2; k++; end
    checks++;
    if (got_q.size() < 1) begin $display("FAIL cap_timeout2"); return; end else passes++;
    g = got_q.pop_front();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (g !== 16'h99FB) $display("FAIL inflight_frame got %h want 99fb", g);
    else passes++;
    checks++;
    if (g !== e) $display("FAIL inflight_sb got %h want %h", g, e);
    else passes++;
  endtask

  task automatic test_reset_mid_shift();
    int k = 0;
    int rc0;
    logic [15:0] g;
    digit_bcd = 24'h123456; dot = 6'h00; blank = 1'b0;
    do_reset();
    @(posedge clk); #2;
    // 35th negedge after the capture edge falls in bit 7's high phase.
    repeat (35) @(negedge clk);
    checks++;
    if ({busy, sclk} !== 2'b11) $display("FAIL mid_bit7_pre got %b want 11", {busy, sclk});
    else passes++;
    rc0 = rck_count;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rclk, sclk, sdio} !== 5'b0)
      $display("FAIL async_reset_outputs got %b want 00000", {busy, done, rclk, sclk, sdio});
    else passes++;
    repeat (3) @(negedge clk);
    got_q.delete();
    rst_n = 1'b1;
    while (got_q.size() < 1 && k < 2 * PERIOD) begin @(posedge clk); #2; k++; end
    checks++;
    if (got_q.size() < 1) begin $display("FAIL post_reset_timeout"); return; end else passes++;
    g = got_q.pop_front();
    checks++;
    if (rck_count !== rc0 + 1) $display("FAIL abandoned_rck got %0d want %0d", rck_count, rc0 + 1);
    else passes++;
    checks++;
    if (g !== 16'h82FE) $display("FAIL post_reset_idx0 got %h want 82fe", g);
    else passes++;
  endtask

  task automatic test_corner();
    int k = 0;
    logic [15:0] g, e;
    digit_bcd = 24'h907381; dot = 6'b101010; blank = 1'b0;
    do_reset();
    while (c_done_t_q.size() < 3 && k < 4 * C_PERIOD) begin @(posedge clk); #2; k++; end
    checks++;
    if (c_done_t_q.size() < 3 || c_got_q.size() < 3) begin
      $display("FAIL corner_timeout got %0d frames want 3", c_got_q.size());
      return;
    end else passes++;
    for (int i = 0; i < 3; i++) begin
      g = c_got_q.pop_front();
      e = (c_exp_q.size() > 0) ? c_exp_q.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) $display("FAIL corner_frame[%0d] got %h want %h", i, g, e);
      else passes++;
      checks++;
      if (c_edges_q[i] !== 16) $display("FAIL corner_sck[%0d] got %0d want 16", i, c_edges_q[i]);
      else passes++;
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (c_done_t_q[i] - c_done_t_q[i-1] !== C_PERIOD)
        $display("FAIL corner_period[%0d] got %0d want %0d", i, c_done_t_q[i] - c_done_t_q[i-1], C_PERIOD);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_scan_wrap();
    test_capture();
    test_reset_mid_shift();
    test_corner();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
